// File: rtl/nec_prefetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nec_prefetch_pkg : shared types and constants for the prefetch queue     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package nec_prefetch_pkg;

  // Decode indexes the queue with pc[2:0], so the depth is pinned to 8.
  localparam int QUEUE_BYTES = 8;
  localparam int IDX_W       = $clog2(QUEUE_BYTES);
  localparam int LEN_W       = IDX_W + 1;
  localparam int ADDR_W      = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } prefetch_state_e;

  function automatic logic [ADDR_W-1:0] phys_addr(input logic [15:0] seg,
                                                  input logic [15:0] ofs);
    return {seg, 4'h0} + {4'h0, ofs};
  endfunction

endpackage
`default_nettype wire

// File: rtl/nec_prefetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nec_prefetch_if : BIU code-fetch port between prefetch unit and BIU      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface nec_prefetch_if;
  import nec_prefetch_pkg::*;

  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_byte;
  logic              bus_ack;
  logic [15:0]       bus_rdata;

  modport master (
    output bus_req,
    output bus_addr,
    output bus_byte,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    input  bus_byte,
    output bus_ack,
    output bus_rdata
  );

endinterface
`default_nettype wire

// File: rtl/nec_prefetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nec_prefetch : 8-byte circular instruction prefetch queue fed by the BIU |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nec_prefetch
  import nec_prefetch_pkg::*;
#(
  parameter int WORD_THRESH = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ce_1,
  input  logic                         ce_2,
  input  logic [15:0]                  cs,
  input  logic                         set_pc,
  input  logic [15:0]                  new_pc,
  input  logic [15:0]                  dec_pc,
  input  logic                         block_prefetch,
  output logic [QUEUE_BYTES-1:0][7:0]  ipq,
  output logic [LEN_W-1:0]             ipq_len,
  nec_prefetch_if.master               bus
);

  localparam logic [LEN_W-1:0] C_WORD_THRESH = LEN_W'(WORD_THRESH);
  localparam logic [LEN_W-1:0] C_BYTE_THRESH = LEN_W'(QUEUE_BYTES - 1);

  prefetch_state_e             r_state,    w_state_nxt;
  logic [15:0]                 r_fetch_ip, w_fetch_ip_nxt;
  logic                        r_bus_req,  w_bus_req_nxt;
  logic [ADDR_W-1:0]           r_bus_addr, w_bus_addr_nxt;
  logic                        r_bus_byte, w_bus_byte_nxt;
  logic [QUEUE_BYTES-1:0][7:0] r_ipq;

  logic                        w_ce;
  logic [15:0]                 w_fill;
  logic [LEN_W-1:0]            w_len;
  logic                        w_room;
  logic                        w_accept;
  logic [IDX_W-1:0]            w_lo_slot;
  logic [IDX_W-1:0]            w_hi_slot;
  logic [QUEUE_BYTES-1:0]      w_slot_we;
  logic [QUEUE_BYTES-1:0][7:0] w_slot_data;

  assign w_ce   = ce_1 | ce_2;
  assign w_fill = r_fetch_ip - dec_pc;
  // A flush hides stale bytes; the queue itself is never cleared.
  assign w_len  = set_pc ? '0 : w_fill[LEN_W-1:0];
  assign w_room = r_fetch_ip[0] ? (w_len <= C_BYTE_THRESH) : (w_len <= C_WORD_THRESH);

  assign w_accept  = (r_state == FETCH) && bus.bus_ack && !set_pc;
  assign w_lo_slot = r_fetch_ip[IDX_W-1:0];
  assign w_hi_slot = w_lo_slot + IDX_W'(1);

  for (genvar i = 0; i < QUEUE_BYTES; i++) begin : g_slot
    localparam logic [IDX_W-1:0] C_IDX = IDX_W'(i);
    assign w_slot_we[i]   = w_accept &&
                            ((w_lo_slot == C_IDX) || (!r_bus_byte && (w_hi_slot == C_IDX)));
    assign w_slot_data[i] = (w_lo_slot == C_IDX) ? bus.bus_rdata[7:0] : bus.bus_rdata[15:8];
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_ip_nxt = r_fetch_ip;
    w_bus_req_nxt  = r_bus_req;
    w_bus_addr_nxt = r_bus_addr;
    w_bus_byte_nxt = r_bus_byte;
    unique case (r_state)
      IDLE: begin
        if (!set_pc && !block_prefetch && w_room) begin
          w_state_nxt    = FETCH;
          w_bus_req_nxt  = 1'b1;
          w_bus_addr_nxt = phys_addr(cs, r_fetch_ip);
          w_bus_byte_nxt = r_fetch_ip[0];
        end
      end
      FETCH: begin
        if (bus.bus_ack) begin
          w_state_nxt   = IDLE;
          w_bus_req_nxt = 1'b0;
          if (!set_pc) begin
            w_fetch_ip_nxt = r_fetch_ip + (r_bus_byte ? 16'd1 : 16'd2);
          end
        end else if (set_pc) begin
          // The BIU cycle cannot be aborted; wait it out and drop the data.
          w_state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.bus_ack) begin
          w_state_nxt   = IDLE;
          w_bus_req_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_bus_req_nxt = 1'b0;
      end
    endcase
    if (set_pc) begin
      w_fetch_ip_nxt = new_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_fetch_ip <= '0;
      r_bus_req  <= 1'b0;
      r_bus_addr <= '0;
      r_bus_byte <= 1'b0;
    end else if (w_ce) begin
      r_state    <= w_state_nxt;
      r_fetch_ip <= w_fetch_ip_nxt;
      r_bus_req  <= w_bus_req_nxt;
      r_bus_addr <= w_bus_addr_nxt;
      r_bus_byte <= w_bus_byte_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ipq <= '0;
    end else if (w_ce) begin
      for (int i = 0; i < QUEUE_BYTES; i++) begin
        if (w_slot_we[i]) begin
          r_ipq[i] <= w_slot_data[i];
        end
      end
    end
  end

  // The room check keeps the fill level within the queue while dec_pc only advances.
  always_ff @(posedge clk) begin
    if (reset_n && !set_pc) begin
      assert (w_fill <= 16'(QUEUE_BYTES));
    end
  end

  assign ipq          = r_ipq;
  assign ipq_len      = w_len;
  assign bus.bus_req  = r_bus_req;
  assign bus.bus_addr = r_bus_addr;
  assign bus.bus_byte = r_bus_byte;

endmodule
`default_nettype wire

// File: tb/tb_nec_prefetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nec_prefetch : self-checking bench with BIU model and request queue   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_nec_prefetch;
  import nec_prefetch_pkg::*;

  typedef struct packed {
    logic [19:0] addr;
    logic        byt;
  } req_t;

  typedef struct packed {
    logic [15:0] dpc;
    logic        spc;
    logic [3:0]  exp_len;
  } len_vec_t;

  logic             clk = 1'b0;
  logic             reset_n, ce_1, ce_2, set_pc, block_prefetch;
  logic [15:0]      cs, new_pc, dec_pc;
  logic [7:0][7:0]  ipq;
  logic [3:0]       ipq_len;

  nec_prefetch_if bif();

  nec_prefetch #(.WORD_THRESH(6)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ce_1           (ce_1),
    .ce_2           (ce_2),
    .cs             (cs),
    .set_pc         (set_pc),
    .new_pc         (new_pc),
    .dec_pc         (dec_pc),
    .block_prefetch (block_prefetch),
    .ipq            (ipq),
    .ipq_len        (ipq_len),
    .bus            (bif)
  );

  always #5 clk = ~clk;

  int       checks = 0;
  int       errors = 0;
  req_t     exp_req[$];
  logic [3:0] exp_len[$];
  logic [3:0] last_len = '0;
  bit       mon_en = 1'b0;
  int       lat_cfg = 0;
  bit       biu_hold = 1'b0;
  bit       biu_force = 1'b0;
  len_vec_t vecs[5];

  function automatic logic [7:0] mem(input logic [19:0] a);
    return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'h3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_en && ipq_len != last_len) begin
      if (exp_len.size() > 0) begin
        chk("len_seq", ipq_len, exp_len.pop_front());
      end else begin
        checks++;
        errors++;
        $display("FAIL len_seq: got %0d, expected no further change", ipq_len);
      end
      last_len = ipq_len;
    end
  endtask

  task automatic wait_idle_len(input logic [3:0] l, input string name);
    int n = 0;
    while (!(ipq_len == l && !bif.bus_req) && n < 80) begin
      tick();
      n++;
    end
    chk(name, ipq_len, l);
  endtask

  task automatic wait_req(input logic [3:0] l, input string name);
    int n = 0;
    while (!(bif.bus_req && ipq_len == l) && n < 80) begin
      tick();
      n++;
    end
    chk(name, bif.bus_req, 1);
  endtask

  task automatic chk_slots(input logic [19:0] base, input string name);
    for (int i = 0; i < 8; i++) begin
      chk(name, ipq[i], mem(base + 20'(i)));
    end
  endtask

  task automatic push_req(input logic [19:0] a, input logic b);
    req_t r;
    r.addr = a;
    r.byt  = b;
    exp_req.push_back(r);
  endtask

  // BIU model: checks each new request against the expected queue, then acks.
  initial begin
    req_t r;
    bit   req_seen = 1'b0;
    int   lat_cnt = 0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    forever begin
      @(negedge clk);
      bif.bus_ack = 1'b0;
      if (bif.bus_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          lat_cnt  = 0;
          if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got addr %05h, expected no request", bif.bus_addr);
          end else begin
            r = exp_req.pop_front();
            chk("req_addr", bif.bus_addr, r.addr);
            chk("req_byte", bif.bus_byte, r.byt);
          end
        end
        if (biu_force || (!biu_hold && lat_cnt >= lat_cfg)) begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = {mem(bif.bus_addr + 20'd1), mem(bif.bus_addr)};
          req_seen      = 1'b0;
        end else begin
          lat_cnt++;
        end
      end else begin
        req_seen = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{dpc: 16'd3, spc: 1'b0, exp_len: 4'd5};
    vecs[1] = '{dpc: 16'd8, spc: 1'b0, exp_len: 4'd0};
    vecs[2] = '{dpc: 16'd7, spc: 1'b0, exp_len: 4'd1};
    vecs[3] = '{dpc: 16'd0, spc: 1'b1, exp_len: 4'd0};
    vecs[4] = '{dpc: 16'd0, spc: 1'b0, exp_len: 4'd8};

    reset_n = 1'b0; ce_1 = 1'b1; ce_2 = 1'b0; cs = 16'hF000;
    set_pc = 1'b0; new_pc = '0; dec_pc = '0; block_prefetch = 1'b0;
    repeat (2) tick();
    chk("rst_req",  bif.bus_req, 0);
    chk("rst_addr", bif.bus_addr, 0);
    chk("rst_byte", bif.bus_byte, 0);
    chk("rst_len",  ipq_len, 0);
    for (int i = 0; i < 8; i++) chk("rst_slot", ipq[i], 0);

    // Fill from reset with zero-latency acks.
    push_req(20'hF0000, 1'b0); push_req(20'hF0002, 1'b0);
    push_req(20'hF0004, 1'b0); push_req(20'hF0006, 1'b0);
    reset_n = 1'b1;
    wait_idle_len(4'd8, "t1_fill");
    repeat (5) tick();
    chk("t1_len", ipq_len, 8);
    chk("t1_idle", bif.bus_req, 0);
    chk_slots(20'hF0000, "t1_slot");
    chk("t1_drained", exp_req.size(), 0);

    // Combinational fill level against dec_pc and set_pc.
    block_prefetch = 1'b1;
    for (int v = 0; v < 5; v++) begin
      dec_pc = vecs[v].dpc;
      set_pc = vecs[v].spc;
      new_pc = 16'd8;
      #1;
      chk("len_vec", ipq_len, vecs[v].exp_len);
      set_pc = 1'b0;
      tick();
    end

    // Branch to odd target: byte fetch then words.
    block_prefetch = 1'b0;
    set_pc = 1'b1; new_pc = 16'h0103; dec_pc = 16'h0103;
    push_req(20'hF0103, 1'b1); push_req(20'hF0104, 1'b0);
    push_req(20'hF0106, 1'b0); push_req(20'hF0108, 1'b0);
    tick();
    set_pc = 1'b0;
    chk("t2_len0", ipq_len, 0);
    last_len = ipq_len;
    exp_len.push_back(4'd1); exp_len.push_back(4'd3);
    exp_len.push_back(4'd5); exp_len.push_back(4'd7);
    mon_en = 1'b1;
    wait_idle_len(4'd7, "t2_fill");
    mon_en = 1'b0;
    chk("t2_len_seq_done", exp_len.size(), 0);
    for (int k = 0; k < 7; k++) chk("t2_slot", ipq[(3 + k) % 8], mem(20'hF0103 + 20'(k)));
    chk("t2_drained", exp_req.size(), 0);

    // Branch while a fetch is stalled: late data must be dropped.
    biu_hold = 1'b1;
    set_pc = 1'b1; new_pc = 16'h0200; dec_pc = 16'h0200;
    push_req(20'hF0200, 1'b0);
    tick();
    set_pc = 1'b0;
    wait_req(4'd0, "t3_req");
    repeat (5) tick();
    set_pc = 1'b1; new_pc = 16'h0300; dec_pc = 16'h0300;
    tick();
    set_pc = 1'b0;
    chk("t3_req_held", bif.bus_req, 1);
    chk("t3_addr_held", bif.bus_addr, 20'hF0200);
    chk("t3_len", ipq_len, 0);
    push_req(20'hF0300, 1'b0); push_req(20'hF0302, 1'b0);
    push_req(20'hF0304, 1'b0); push_req(20'hF0306, 1'b0);
    biu_hold = 1'b0;
    tick();
    chk("t3_discard_len", ipq_len, 0);
    chk("t3_discard_req", bif.bus_req, 0);
    wait_idle_len(4'd8, "t3_fill");
    chk_slots(20'hF0300, "t3_slot");
    chk("t3_drained", exp_req.size(), 0);

    // block_prefetch with a fetch in flight, then clock-enable gated resume.
    lat_cfg = 3;
    set_pc = 1'b1; new_pc = 16'h0400; dec_pc = 16'h0400;
    push_req(20'hF0400, 1'b0); push_req(20'hF0402, 1'b0);
    tick();
    set_pc = 1'b0;
    wait_req(4'd2, "t4_req2");
    block_prefetch = 1'b1;
    wait_idle_len(4'd4, "t4_inflight");
    repeat (8) tick();
    chk("t4_blocked_req", bif.bus_req, 0);
    chk("t4_blocked_len", ipq_len, 4);
    ce_1 = 1'b0;
    block_prefetch = 1'b0;
    push_req(20'hF0404, 1'b0); push_req(20'hF0406, 1'b0);
    repeat (3) tick();
    chk("t4_ce_hold", bif.bus_req, 0);
    ce_2 = 1'b1;
    tick();
    chk("t4_resume", bif.bus_req, 1);
    ce_1 = 1'b1; ce_2 = 1'b0;
    wait_idle_len(4'd8, "t4_fill");
    chk_slots(20'hF0400, "t4_slot");
    chk("t4_drained", exp_req.size(), 0);

    // IP and physical address wrap.
    lat_cfg = 0;
    cs = 16'hFFFF;
    set_pc = 1'b1; new_pc = 16'hFFFF; dec_pc = 16'hFFFF;
    push_req(20'h0FFEF, 1'b1); push_req(20'hFFFF0, 1'b0);
    push_req(20'hFFFF2, 1'b0); push_req(20'hFFFF4, 1'b0);
    tick();
    set_pc = 1'b0;
    last_len = ipq_len;
    exp_len.push_back(4'd1); exp_len.push_back(4'd3);
    exp_len.push_back(4'd5); exp_len.push_back(4'd7);
    mon_en = 1'b1;
    wait_idle_len(4'd7, "t5_fill");
    mon_en = 1'b0;
    chk("t5_len_seq_done", exp_len.size(), 0);
    chk("t5_slot7", ipq[7], mem(20'h0FFEF));
    for (int i = 0; i < 6; i++) chk("t5_slot", ipq[i], mem(20'hFFFF0 + 20'(i)));
    chk("t5_drained", exp_req.size(), 0);

    // Reset mid-fetch with a coincident ack.
    cs = 16'hF000;
    biu_hold = 1'b1;
    set_pc = 1'b1; new_pc = 16'h0500; dec_pc = 16'h0500;
    push_req(20'hF0500, 1'b0);
    tick();
    set_pc = 1'b0;
    wait_req(4'd0, "t6_req");
    repeat (2) tick();
    reset_n = 1'b0;
    dec_pc = 16'h0000;
    biu_force = 1'b1;
    tick();
    biu_force = 1'b0;
    biu_hold = 1'b0;
    chk("t6_req",  bif.bus_req, 0);
    chk("t6_addr", bif.bus_addr, 0);
    chk("t6_byte", bif.bus_byte, 0);
    chk("t6_len",  ipq_len, 0);
    for (int i = 0; i < 8; i++) chk("t6_slot", ipq[i], 0);
    repeat (2) tick();
    chk("t6_quiet", bif.bus_req, 0);
    chk("t6_drained", exp_req.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
